// File: rtl/h263_pkg.sv
// Shared H.263 pipeline definitions: block geometry, TCOEF event type and packing,
// and the run-length encoder state encoding.
package h263_pkg;

  localparam int BLOCK_SIZE      = 64;
  localparam int RUN_WIDTH       = 6;
  localparam int MAX_VALUE_WIDTH = 32;
  localparam int MAX_WORD_WIDTH  = 64;

  typedef enum logic {RUN, FLUSH} rle_state_t;

  typedef struct packed {
    logic                              last;
    logic        [RUN_WIDTH-1:0]       run;
    logic signed [MAX_VALUE_WIDTH-1:0] level;
  } tcoef_evt_t;

  // Word layout: LEVEL in [vw-1:0], RUN above it, LAST above RUN, zeros beyond.
  function automatic logic [MAX_WORD_WIDTH-1:0] pack_tcoef(input tcoef_evt_t evt,
                                                           input int value_width);
    logic [MAX_WORD_WIDTH-1:0] one;
    logic [MAX_WORD_WIDTH-1:0] mask;
    logic [MAX_WORD_WIDTH-1:0] word;
    one  = {{(MAX_WORD_WIDTH-1){1'b0}}, 1'b1};
    mask = (one << value_width) - one;
    word = MAX_WORD_WIDTH'(evt.level) & mask;
    word = word | (MAX_WORD_WIDTH'(evt.run) << value_width);
    word = word | (MAX_WORD_WIDTH'(evt.last) << (value_width + RUN_WIDTH));
    return word;
  endfunction

  function automatic tcoef_evt_t unpack_tcoef(input logic [MAX_WORD_WIDTH-1:0] word,
                                              input int value_width);
    tcoef_evt_t evt;
    evt.level = MAX_VALUE_WIDTH'($signed(word << (MAX_WORD_WIDTH - value_width))
                                 >>> (MAX_WORD_WIDTH - value_width));
    evt.run   = RUN_WIDTH'(word >> value_width);
    evt.last  = word[value_width + RUN_WIDTH];
    return evt;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register: holds a beat stable until the
// downstream accepts it and reports whether a new beat may be loaded.
module axis_out_reg #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              free
);

  // Free when empty or when the current beat leaves on this edge.
  assign free = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/run_length_enc.sv
// Run-length encoder: turns 64 zig-zag ordered coefficients per block into
// (LAST, RUN, LEVEL) events, holding one pending event so LAST can be marked.
module run_length_enc
  import h263_pkg::*;
#(
  parameter int VALUE_WIDTH     = 17,
  parameter int AXIS_DATA_WIDTH = 8*((VALUE_WIDTH-1)/8+1),
  parameter int OUT_DATA_WIDTH  = 8*((VALUE_WIDTH+6)/8+1)
) (
  input  logic                       i_clk,
  input  logic                       i_areset,
  input  logic                       i_axis_TVALID,
  output logic                       o_axis_TREADY,
  input  logic [AXIS_DATA_WIDTH-1:0] i_axis_TDATA,
  input  logic                       i_axis_TLAST,
  output logic                       o_axis_TVALID,
  input  logic                       i_axis_TREADY,
  output logic [OUT_DATA_WIDTH-1:0]  o_axis_TDATA,
  output logic                       o_axis_TLAST
);

  localparam logic [RUN_WIDTH-1:0] LAST_IDX = RUN_WIDTH'(BLOCK_SIZE - 1);

  rle_state_t                    state, state_n;
  logic [RUN_WIDTH-1:0]          idx, idx_n;
  logic [RUN_WIDTH-1:0]          zrun, zrun_n;
  logic [RUN_WIDTH-1:0]          p_run, p_run_n;
  logic                          p_valid, p_valid_n;
  logic signed [VALUE_WIDTH-1:0] p_level, p_level_n;
  logic signed [VALUE_WIDTH-1:0] coef;
  logic                          ready, accept, emit, out_free;
  tcoef_evt_t                    evt;
  logic [OUT_DATA_WIDTH-1:0]     evt_word;
  logic                          unused_in;

  function automatic tcoef_evt_t make_evt(input logic                          last,
                                          input logic [RUN_WIDTH-1:0]          run,
                                          input logic signed [VALUE_WIDTH-1:0] level);
    tcoef_evt_t e;
    e.last  = last;
    e.run   = run;
    e.level = MAX_VALUE_WIDTH'(level);
    return e;
  endfunction

  assign coef          = i_axis_TDATA[VALUE_WIDTH-1:0];
  assign unused_in     = ^{i_axis_TLAST, i_axis_TDATA};
  assign o_axis_TREADY = ready;
  assign evt_word      = OUT_DATA_WIDTH'(pack_tcoef(evt, VALUE_WIDTH));

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state   <= RUN;
      idx     <= '0;
      zrun    <= '0;
      p_valid <= 1'b0;
      p_run   <= '0;
      p_level <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      zrun    <= zrun_n;
      p_valid <= p_valid_n;
      p_run   <= p_run_n;
      p_level <= p_level_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    zrun_n    = zrun;
    p_valid_n = p_valid;
    p_run_n   = p_run;
    p_level_n = p_level;
    ready     = 1'b0;
    accept    = 1'b0;
    emit      = 1'b0;
    evt       = '0;
    unique case (state)
      RUN: begin
        ready  = out_free;
        accept = i_axis_TVALID && ready;
        if (accept && idx != LAST_IDX) begin
          idx_n = idx + 1'b1;
          if (coef != '0) begin
            emit      = p_valid;
            evt       = make_evt(1'b0, p_run, p_level);
            p_valid_n = 1'b1;
            p_run_n   = zrun;
            p_level_n = coef;
            zrun_n    = '0;
          end else begin
            zrun_n = zrun + 1'b1;
          end
        end else if (accept) begin
          // Block end: the pending event (if any) is the only thing that decides LAST.
          idx_n     = '0;
          zrun_n    = '0;
          p_valid_n = 1'b0;
          emit      = 1'b1;
          if (coef != '0 && p_valid) begin
            evt       = make_evt(1'b0, p_run, p_level);
            p_valid_n = 1'b1;
            p_run_n   = zrun;
            p_level_n = coef;
            state_n   = FLUSH;
          end else if (coef != '0) begin
            evt = make_evt(1'b1, zrun, coef);
          end else if (p_valid) begin
            evt = make_evt(1'b1, p_run, p_level);
          end else begin
            evt = make_evt(1'b1, LAST_IDX, '0);
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          emit      = 1'b1;
          evt       = make_evt(1'b1, p_run, p_level);
          p_valid_n = 1'b0;
          state_n   = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  axis_out_reg #(
    .DATA_W(OUT_DATA_WIDTH)
  ) u_out (
    .clk      (i_clk),
    .rst      (i_areset),
    .load     (emit),
    .load_data(evt_word),
    .load_last(evt.last),
    .ready    (i_axis_TREADY),
    .valid    (o_axis_TVALID),
    .data     (o_axis_TDATA),
    .last     (o_axis_TLAST),
    .free     (out_free)
  );

endmodule

// File: tb/tb_run_length_enc.sv
// Directed bench for run_length_enc: ramps, sparse and empty blocks,
// output back-pressure and mid-block reset, with hand-computed event lists.
module tb_run_length_enc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;
  logic        out_last;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          bubbles = 0;
  bit          tog = 1'b0;
  bit          stalled = 1'b0;
  logic [24:0] held = '0;
  logic [24:0] got_q[$];
  logic [24:0] exp_q[$];
  logic signed [16:0] blk[64];

  run_length_enc dut (
    .i_clk        (clk),
    .i_areset     (rst),
    .i_axis_TVALID(in_valid),
    .o_axis_TREADY(in_ready),
    .i_axis_TDATA (in_data),
    .i_axis_TLAST (in_last),
    .o_axis_TVALID(out_valid),
    .i_axis_TREADY(out_ready),
    .o_axis_TDATA (out_data),
    .o_axis_TLAST (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Expected beat: {TLAST, LAST, RUN[5:0], LEVEL[16:0]}
  function automatic logic [24:0] mk(input bit last, input int run, input int lvl);
    return {last, last, 6'(run), 17'(lvl)};
  endfunction

  always @(posedge clk) begin
    #1;
    if (tog) out_ready = ~out_ready;
    else     out_ready = 1'b1;
  end

  // Inputs and ready change only at posedge+1, so a negedge sample predicts the next edge.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("hold_stable", 32'({out_valid, out_last, out_data}), 32'({1'b1, held}));
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (!in_ready) bubbles++;
      stalled = out_valid && !out_ready;
      held    = {out_last, out_data};
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_coef(input logic signed [16:0] v);
    bit done = 1'b0;
    int waited = 0;
    in_valid = 1'b1;
    in_data  = {7'h2A, v};
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      if (!done) begin
        waited++;
        if (waited > 200) begin
          check("accept_timeout", 32'(waited), 32'(0));
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) begin
      in_last = (i == 10);
      send_coef(blk[i]);
    end
    in_last = 1'b0;
  endtask

  task automatic check_events(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) check($sformatf("%s_evt%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_events(input int n);
    int w = 0;
    while (got_q.size() < n && w < 400) begin
      @(posedge clk);
      #1;
      w++;
    end
  endtask

  task automatic load_ramp(input int sign);
    for (int i = 0; i < 64; i++) blk[i] = 17'(sign * (i + 1));
  endtask

  task automatic load_sparse();
    for (int i = 0; i < 64; i++) blk[i] = '0;
    blk[0] = 17'sd5;
    blk[3] = -17'sd2;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(out_valid), 32'(0));
    check("rst_tdata",  32'(out_data),  32'(0));
    check("rst_tlast",  32'(out_last),  32'(0));
    check("rst_tready", 32'(in_ready),  32'(1));
    rst = 1'b0;
    idle(2);

    // Positive ramp: one bubble for the FLUSH of coefficient 64
    load_ramp(1);
    bubbles = 0;
    send_n(64);
    idle(4);
    check("pos_bubbles", 32'(bubbles), 32'(1));
    for (int i = 1; i <= 64; i++) exp_q.push_back(mk(i == 64, 0, i));
    check_events("pos");

    // Negative ramp: sign preserved, final word fixed
    load_ramp(-1);
    send_n(64);
    idle(4);
    check("neg_last_word", 32'(got_q[63]), 32'(25'h1_81FFC0));
    for (int i = 1; i <= 64; i++) exp_q.push_back(mk(i == 64, 0, -i));
    check_events("neg");

    // Sparse block
    load_sparse();
    bubbles = 0;
    send_n(64);
    idle(4);
    check("sparse_bubbles", 32'(bubbles), 32'(0));
    exp_q.push_back(mk(0, 0, 5));
    exp_q.push_back(mk(1, 2, -2));
    check_events("sparse");

    // All-zero block followed immediately by the sparse block
    for (int i = 0; i < 64; i++) blk[i] = '0;
    bubbles = 0;
    send_n(64);
    load_sparse();
    send_n(64);
    idle(4);
    check("b2b_bubbles", 32'(bubbles), 32'(0));
    exp_q.push_back(mk(1, 63, 0));
    exp_q.push_back(mk(0, 0, 5));
    exp_q.push_back(mk(1, 2, -2));
    check_events("b2b");

    // Back-pressure: downstream ready toggles every cycle
    tog = 1'b1;
    load_ramp(1);
    send_n(64);
    wait_events(64);
    tog = 1'b0;
    idle(4);
    for (int i = 1; i <= 64; i++) exp_q.push_back(mk(i == 64, 0, i));
    check_events("bp");

    // Mid-block reset after 30 coefficients, then a full block from idx 0
    load_ramp(1);
    send_n(30);
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 32'(out_valid), 32'(0));
    check("mid_rst_tdata",  32'(out_data),  32'(0));
    check("mid_rst_tlast",  32'(out_last),  32'(0));
    check("mid_rst_tready", 32'(in_ready),  32'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    got_q.delete();
    load_ramp(1);
    send_n(64);
    idle(4);
    for (int i = 1; i <= 64; i++) exp_q.push_back(mk(i == 64, 0, i));
    check_events("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
